// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Tnew/Tuse hazard unit for a multi-stage MIPS pipeline.  Each stage after D
// (stage 1 = E ... stage STAGES = W) carries a (destination, Tnew) record.
// A record's Tnew counts down, saturating at zero, as it moves down the pipe.
// D-stage sources are compared against these records to decide between
// stalling and forwarding.  A busy counter for the mult/div unit stalls any
// instruction that needs HI/LO or the unit itself while an operation runs.
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset
//   d_valid      D holds a real instruction (0 = bubble)
//   d_rs, d_rt   D source registers
//   d_tuse_rs/rt Tuse of each source, 3 = source unused
//   d_dst        D destination register (0 = none)
//   d_tnew       Tnew of the D instruction on entering stage 1
//   d_md_start   D is mult/multu/div/divu
//   d_md_div     with d_md_start: 1 = div class, 0 = mult class
//   d_md_use     D needs the mult/div unit idle
//   stall        freeze PC/F/D and insert a bubble into stage 1
//   fwd_sel_rs   0 = register file, k = forward from stage k
//   fwd_sel_rt   same for rt
//   md_busy      mult/div busy counter is nonzero
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int STAGES   = 3,
   parameter int TNEW_W   = 2,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int SEL_W    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [4:0]        d_rs,
   input  logic [4:0]        d_rt,
   input  logic [1:0]        d_tuse_rs,
   input  logic [1:0]        d_tuse_rt,
   input  logic [4:0]        d_dst,
   input  logic [TNEW_W-1:0] d_tnew,
   input  logic              d_md_start,
   input  logic              d_md_div,
   input  logic              d_md_use,
   output logic              stall,
   output logic [SEL_W-1:0]  fwd_sel_rs,
   output logic [SEL_W-1:0]  fwd_sel_rt,
   output logic              md_busy
);

   localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int MD_W   = $clog2(MD_MAX + 1);

   logic [4:0]        dst_q  [1:STAGES];
   logic [4:0]        dst_d  [1:STAGES];
   logic [TNEW_W-1:0] tnew_q [1:STAGES];
   logic [TNEW_W-1:0] tnew_d [1:STAGES];
   logic [MD_W-1:0]   md_cnt_q;
   logic [MD_W-1:0]   md_cnt_d;

   logic [SEL_W-1:0]  hit_rs;
   logic [SEL_W-1:0]  hit_rt;
   logic [TNEW_W-1:0] hit_tnew_rs;
   logic [TNEW_W-1:0] hit_tnew_rt;
   logic              haz_rs;
   logic              haz_rt;
   logic              haz_md;
   logic              accept;

   // Nearest matching stage per source.  The scan runs from the oldest stage
   // to the youngest so a younger record overwrites (shadows) an older one.
   always_comb begin
      hit_rs      = '0;
      hit_rt      = '0;
      hit_tnew_rs = '0;
      hit_tnew_rt = '0;
      for (int k = STAGES; k >= 1; k--) begin
         if ((d_rs != 5'd0) && (dst_q[k] == d_rs)) begin
            hit_rs      = SEL_W'(k);
            hit_tnew_rs = tnew_q[k];
         end
         if ((d_rt != 5'd0) && (dst_q[k] == d_rt)) begin
            hit_rt      = SEL_W'(k);
            hit_tnew_rt = tnew_q[k];
         end
      end
   end

   assign md_busy = (md_cnt_q != '0);

   assign haz_rs = (d_tuse_rs != 2'd3) && (hit_rs != '0) &&
                   (32'(hit_tnew_rs) > 32'(d_tuse_rs));
   assign haz_rt = (d_tuse_rt != 2'd3) && (hit_rt != '0) &&
                   (32'(hit_tnew_rt) > 32'(d_tuse_rt));
   assign haz_md = d_md_use && md_busy;

   assign stall  = d_valid && (haz_rs || haz_rt || haz_md);
   assign accept = d_valid && !stall;

   // Only a result that is already final (Tnew 0) can feed D.  A match that
   // is still being produced reads 0 here and is picked up later in the pipe.
   assign fwd_sel_rs = ((hit_rs != '0) && (hit_tnew_rs == '0)) ? hit_rs : '0;
   assign fwd_sel_rt = ((hit_rt != '0) && (hit_tnew_rt == '0)) ? hit_rt : '0;

   always_comb begin
      dst_d[1]  = accept ? d_dst  : 5'd0;
      tnew_d[1] = accept ? d_tnew : '0;
      // Older stages keep moving during a stall so every hazard drains.
      for (int k = 2; k <= STAGES; k++) begin
         dst_d[k]  = dst_q[k-1];
         tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TNEW_W'(1);
      end
   end

   always_comb begin
      md_cnt_d = md_cnt_q;
      if (accept && d_md_start) begin
         md_cnt_d = d_md_div ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - MD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= STAGES; k++) begin
            dst_q[k]  <= 5'd0;
            tnew_q[k] <= '0;
         end
         md_cnt_q <= '0;
      end else begin
         dst_q    <= dst_d;
         tnew_q   <= tnew_d;
         md_cnt_q <= md_cnt_d;
      end
   end

endmodule
